mastermind_scorer: RTL
======================

// Module: mastermind_scorer
// PURPOSE
// Parametrised successor to the 4-peg compare unit. Holds a secret code of PEGS pegs of
// COLOR_W bits each and scores guesses sequentially with correct duplicate handling.
// Also tracks the guess count and win/lose status.
// Sits between the input-collection FSM (which assembles code/guess words) and the HEX display logic.
// PARAMETERS
// PEGS         4  number of pegs per code/guess (2..8)
// COLOR_W      3  bits per peg colour
// MAX_GUESSES  8  guess limit before loss (used only with MASTERMIND_GUESS_LIMIT_EN)
// PORTS
// clk           in   1              system clock
// reset         in   1              synchronous, active-high reset
// code_load     in   1              pulse: latch code_in, start new game
// code_in       in   PEGS*COLOR_W   secret code, peg i at [i*COLOR_W +: COLOR_W]
// guess_valid   in   1              guess_in offered
// guess_ready   out  1              scorer can accept a guess
// guess_in      in   PEGS*COLOR_W   guess, same packing as code_in
// result_valid  out  1              one-cycle pulse: red/white valid
// red           out  $clog2(PEGS+1) right colour, right position
// white         out  $clog2(PEGS+1) right colour, wrong position
// guesses_used  out  $clog2(MAX_GUESSES+1)  scored guesses this game
// win           out  1              sticky until code_load/reset
// lose          out  1              sticky until code_load/reset
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset: state NO_CODE; all outputs 0; internal used masks cleared.
// - States: NO_CODE, ARMED, RED_PASS, WHITE_PASS, REPORT, GAME_OVER.
// - code_load in any state: latch code; clear red/white/guesses_used/win/lose and masks; go ARMED.
//   This aborts any scoring in progress without a result_valid pulse.
// - code_load has priority over a simultaneous guess_valid; that guess is not accepted.
// - guess_ready=1 only in ARMED. Accept on guess_valid&&guess_ready.
// - On accept: latch guess, clear masks and counts, set idx=0, go RED_PASS.
// - RED_PASS, one peg per cycle, idx 0..PEGS-1:
//   - if code[idx]==guess[idx], red++ and set used_c[idx] and used_g[idx].
// - WHITE_PASS, one code peg per cycle, idx 0..PEGS-1:
//   - if !used_c[idx], find the lowest j with !used_g[j] && guess[j]==code[idx].
//   - if found, white++ and set used_g[j].
// - REPORT: result_valid=1 for 1 cycle, guesses_used++ (saturating at max).
//   - red==PEGS -> win=1, go GAME_OVER.
//   - elif limit reached -> lose=1, go GAME_OVER.
//   - else go ARMED.
// - Latency: accept edge -> result_valid is exactly 2*PEGS+1 cycles.
// - red/white hold their last result until the next accept or code_load; red+white<=PEGS.
// - GAME_OVER: guess_ready=0; only code_load or reset leaves it.
// - guess_valid in NO_CODE is ignored.
// CONFIGURATION
// MASTERMIND_GUESS_LIMIT_EN defined:
//   - after the MAX_GUESSES-th scored guess without a win, lose=1 in REPORT, go GAME_OVER.
// Not defined:
//   - lose is tied to 0; play is unlimited.
//   - guesses_used saturates at 2^width-1.
//   - MAX_GUESSES only sizes guesses_used.
// TESTING (PEGS=4, COLOR_W=3, pegs listed 0..3)
// Code 1,2,3,4; guess 1,2,3,4 -> result_valid at accept+9 cycles, red=4 white=0 win=1;
//   next guess_valid not accepted (guess_ready=0).
// Code 1,1,2,2; guess 2,2,1,1 -> red=0 white=4. Guess 1,2,1,2 -> red=2 white=2.
// Code 1,2,3,4; guess 5,5,5,1 -> red=0 white=1; guess 1,1,1,1 -> red=1 white=0 (dup handling).
// LIMIT_EN, MAX_GUESSES=8: eight guesses of 0,0,0,0 vs code 7,7,7,7.
//   -> 8th result has lose=1, guesses_used=8, guess_ready=0.
//   - code_load then clears all flags, guess_ready=1.
// code_load asserted 3 cycles into RED_PASS -> no result_valid; ARMED next cycle.
//   - guess_valid asserted with code_load is not accepted.
// reset asserted mid-WHITE_PASS -> next cycle all outputs 0, state NO_CODE, guess_ready=0.

Source files
------------

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: red pass then white pass, one peg per cycle, with game status.
// Define MASTERMIND_GUESS_LIMIT_EN to end the game with a loss after MAX_GUESSES scored guesses.
module mastermind_scorer #(
    parameter int unsigned PEGS        = 4,
    parameter int unsigned COLOR_W     = 3,
    parameter int unsigned MAX_GUESSES = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               code_load,
    input  logic [PEGS*COLOR_W-1:0]            code_in,
    input  logic                               guess_valid,
    output logic                               guess_ready,
    input  logic [PEGS*COLOR_W-1:0]            guess_in,
    output logic                               result_valid,
    output logic [$clog2(PEGS+1)-1:0]          red,
    output logic [$clog2(PEGS+1)-1:0]          white,
    output logic [$clog2(MAX_GUESSES+1)-1:0]   guesses_used,
    output logic                               win,
    output logic                               lose
);

    localparam int unsigned CntW   = $clog2(PEGS + 1);
    localparam int unsigned GuessW = $clog2(MAX_GUESSES + 1);
    localparam int unsigned IdxW   = $clog2(PEGS);

    typedef enum logic [2:0] {
        StNoCode, StArmed, StRedPass, StWhitePass, StReport, StGameOver
    } state_e;

    state_e                           state_q, state_d;
    logic [PEGS-1:0][COLOR_W-1:0]     code_q, code_d;
    logic [PEGS-1:0][COLOR_W-1:0]     guess_q, guess_d;
    logic [PEGS-1:0]                  used_c_q, used_c_d;
    logic [PEGS-1:0]                  used_g_q, used_g_d;
    logic [IdxW-1:0]                  idx_q, idx_d;
    logic [CntW-1:0]                  red_q, red_d;
    logic [CntW-1:0]                  white_q, white_d;
    logic [GuessW-1:0]                guesses_q, guesses_d, guesses_inc;
    logic                             win_q, win_d;
    logic                             lose_q, lose_d;
    logic                             rv_q, rv_d;
    logic [PEGS-1:0]                  white_hit;
    logic                             found;
    logic                             limit_hit;

`ifdef MASTERMIND_GUESS_LIMIT_EN
    localparam logic [GuessW-1:0] GuessMax = GuessW'(MAX_GUESSES);
    assign limit_hit = (guesses_inc >= GuessMax);
`else
    localparam logic [GuessW-1:0] GuessMax = {GuessW{1'b1}};
    assign limit_hit = 1'b0;
`endif

    assign guesses_inc = (guesses_q == GuessMax) ? guesses_q : guesses_q + GuessW'(1);

    // Lowest unused guess peg matching the current code peg.
    always_comb begin
        white_hit = '0;
        found     = 1'b0;
        for (int unsigned j = 0; j < PEGS; j++) begin
            if (!found && !used_g_q[j] && guess_q[j] == code_q[idx_q]) begin
                white_hit[j] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        guess_d   = guess_q;
        used_c_d  = used_c_q;
        used_g_d  = used_g_q;
        idx_d     = idx_q;
        red_d     = red_q;
        white_d   = white_q;
        guesses_d = guesses_q;
        win_d     = win_q;
        lose_d    = lose_q;
        rv_d      = 1'b0;
        if (code_load) begin
            code_d    = code_in;
            used_c_d  = '0;
            used_g_d  = '0;
            idx_d     = '0;
            red_d     = '0;
            white_d   = '0;
            guesses_d = '0;
            win_d     = 1'b0;
            lose_d    = 1'b0;
            state_d   = StArmed;
        end else begin
            unique case (state_q)
                StNoCode: ;
                StArmed: begin
                    if (guess_valid) begin
                        guess_d  = guess_in;
                        used_c_d = '0;
                        used_g_d = '0;
                        idx_d    = '0;
                        red_d    = '0;
                        white_d  = '0;
                        state_d  = StRedPass;
                    end
                end
                StRedPass: begin
                    if (code_q[idx_q] == guess_q[idx_q]) begin
                        red_d           = red_q + CntW'(1);
                        used_c_d[idx_q] = 1'b1;
                        used_g_d[idx_q] = 1'b1;
                    end
                    if (idx_q == IdxW'(PEGS - 1)) begin
                        idx_d   = '0;
                        state_d = StWhitePass;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
                StWhitePass: begin
                    if (!used_c_q[idx_q] && found) begin
                        white_d  = white_q + CntW'(1);
                        used_g_d = used_g_q | white_hit;
                    end
                    if (idx_q == IdxW'(PEGS - 1)) begin
                        idx_d   = '0;
                        state_d = StReport;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
                StReport: begin
                    // result_valid is registered, so the pulse lands one cycle after REPORT.
                    rv_d      = 1'b1;
                    guesses_d = guesses_inc;
                    if (red_q == CntW'(PEGS)) begin
                        win_d   = 1'b1;
                        state_d = StGameOver;
                    end else if (limit_hit) begin
                        lose_d  = 1'b1;
                        state_d = StGameOver;
                    end else begin
                        state_d = StArmed;
                    end
                end
                StGameOver: ;
                default: state_d = StNoCode;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StNoCode;
            code_q    <= '0;
            guess_q   <= '0;
            used_c_q  <= '0;
            used_g_q  <= '0;
            idx_q     <= '0;
            red_q     <= '0;
            white_q   <= '0;
            guesses_q <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            guess_q   <= guess_d;
            used_c_q  <= used_c_d;
            used_g_q  <= used_g_d;
            idx_q     <= idx_d;
            red_q     <= red_d;
            white_q   <= white_d;
            guesses_q <= guesses_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            rv_q      <= rv_d;
        end
    end

    assign guess_ready  = (state_q == StArmed);
    assign result_valid = rv_q;
    assign red          = red_q;
    assign white        = white_q;
    assign guesses_used = guesses_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule
